// File: rtl/coin_classifier.sv
// Coin pulse-width classifier: measures sensor-high width, matches it against per-coin windows, flags jams.
// Optional running credit total is compiled in with COIN_CREDIT_EN; without it credit reads 0.
module coin_classifier #(
    parameter int                            NUM_COINS   = 3,
    parameter int                            CNT_W       = 8,
    parameter logic [NUM_COINS*CNT_W-1:0]    MIN_TABLE   = {8'd10, 8'd6, 8'd2},
    parameter logic [NUM_COINS*CNT_W-1:0]    MAX_TABLE   = {8'd12, 8'd8, 8'd4},
    parameter int                            VALUE_W     = 8,
    parameter logic [NUM_COINS*VALUE_W-1:0]  VALUE_TABLE = {8'd25, 8'd5, 8'd10},
    parameter int                            CREDIT_W    = 12,
    parameter int                            JAM_LIMIT   = 255,
    parameter int                            IDX_W       = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coinSensor,
    input  logic                 creditClear,
    output logic                 coinValid,
    output logic [IDX_W-1:0]     coinIndex,
    output logic [NUM_COINS-1:0] coinDetected,
    output logic                 coinReject,
    output logic                 jam,
    output logic [CREDIT_W-1:0]  credit
);

    typedef enum logic [1:0] {SETTLE, IDLE, MEASURE, JAM} state_t;

    localparam logic [CNT_W-1:0] JAM_CNT = CNT_W'(JAM_LIMIT);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 valid_q, reject_q, jam_q;
    logic [IDX_W-1:0]     index_q;
    logic [NUM_COINS-1:0] detected_q;

    logic                 hit, miss;
    logic                 match_vld;
    logic [IDX_W-1:0]     match_idx;
    logic [VALUE_W-1:0]   match_val;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        match_vld = 1'b0;
        match_idx = '0;
        match_val = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (count_q >= MIN_TABLE[i*CNT_W +: CNT_W] &&
                count_q <= MAX_TABLE[i*CNT_W +: CNT_W]) begin
                match_vld = 1'b1;
                match_idx = IDX_W'(i);
                match_val = VALUE_TABLE[i*VALUE_W +: VALUE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hit     = 1'b0;
        miss    = 1'b0;
        case (state_q)
            SETTLE: begin
                if (!coinSensor) state_d = IDLE;
            end
            IDLE: begin
                if (coinSensor) begin
                    count_d = CNT_W'(1);
                    state_d = (JAM_CNT == CNT_W'(1)) ? JAM : MEASURE;
                end
            end
            MEASURE: begin
                if (coinSensor) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_d == JAM_CNT) state_d = JAM;
                end else begin
                    hit     = match_vld;
                    miss    = !match_vld;
                    state_d = IDLE;
                end
            end
            JAM: begin
                if (!coinSensor) state_d = IDLE;
            end
            default: state_d = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SETTLE;
            count_q    <= '0;
            valid_q    <= 1'b0;
            reject_q   <= 1'b0;
            jam_q      <= 1'b0;
            index_q    <= '0;
            detected_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            valid_q    <= hit;
            reject_q   <= miss;
            jam_q      <= (state_d == JAM);
            detected_q <= hit ? (NUM_COINS'(1) << match_idx) : '0;
            if (hit) index_q <= match_idx;
        end
    end

`ifdef COIN_CREDIT_EN
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] credit_base;
    logic [CREDIT_W:0]   credit_sum;

    // Clear is applied before the add, so a coin landing with a clear leaves just its own value.
    always_comb begin
        credit_base = creditClear ? '0 : credit_q;
        credit_sum  = {1'b0, credit_base} + {{(CREDIT_W + 1 - VALUE_W){1'b0}}, match_val};
        credit_d    = credit_base;
        if (hit) credit_d = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) credit_q <= '0;
        else       credit_q <= credit_d;
    end

    assign credit = credit_q;
`else
    logic unused_credit_inputs;
    assign unused_credit_inputs = ^{creditClear, match_val};
    assign credit = '0;
`endif

    assign coinValid    = valid_q;
    assign coinReject   = reject_q;
    assign coinIndex    = index_q;
    assign coinDetected = detected_q;
    assign jam          = jam_q;

endmodule

// File: doc/coin_classifier.md
# coin_classifier

Parametrised coin pulse-width classifier for the vending datapath. Measures how long `coinSensor` stays high as a coin passes, then matches the width against NUM_COINS programmable [min,max] windows. Emits a one-cycle detect pulse with coin index (or a reject pulse), flags jammed coins, and optionally keeps a running credit total for the vend controller.

## Interface
Parameters:
- `NUM_COINS`, 3, number of coin classes (1..8)
- `CNT_W`, 8, width counter width
- `MIN_TABLE`, {8'd10,8'd6,8'd2}, packed NUM_COINS×CNT_W; entry i = minimum width of coin i (entry 0 in LSBs)
- `MAX_TABLE`, {8'd12,8'd8,8'd4}, packed NUM_COINS×CNT_W; entry i = maximum width of coin i
- `VALUE_W`, 8, coin value width
- `VALUE_TABLE`, {8'd25,8'd5,8'd10}, packed NUM_COINS×VALUE_W; cents per coin (quarter, nickel, dime)
- `CREDIT_W`, 12, credit accumulator width
- `JAM_LIMIT`, 255, width in cycles that declares a jam; must be ≤ 2^CNT_W−1

Ports:
- `clk` in 1 — system clock, rising edge
- `reset` in 1 — synchronous, active-high
- `coinSensor` in 1 — high while a coin blocks the sensor (already synchronised)
- `creditClear` in 1 — synchronous request to zero credit
- `coinValid` out 1 — one-cycle pulse, valid coin classified
- `coinIndex` out $clog2(NUM_COINS) (min 1) — index of classified coin, held until next coinValid
- `coinDetected` out NUM_COINS — one-hot, high with coinValid only
- `coinReject` out 1 — one-cycle pulse, width matched no window
- `jam` out 1 — high while in JAM
- `credit` out CREDIT_W — accumulated value

## Operation
- States: SETTLE, IDLE, MEASURE, JAM. Reset enters SETTLE.
- SETTLE: wait for `coinSensor`=0 → IDLE (discards a coin partially seen across reset).
- IDLE: `coinSensor`=1 → MEASURE, count=1.
- MEASURE, sensor=1: count+1; if new count = JAM_LIMIT → JAM.
- MEASURE, sensor=0: classify count; → IDLE. Lowest index i with MIN[i] ≤ count ≤ MAX[i] wins (overlapping windows resolved by priority). Match: coinValid=1, coinDetected[i]=1, coinIndex=i. No match: coinReject=1.
- JAM: `jam`=1; no classification; sensor=0 → IDLE with jam=0, no reject pulse.
- A new coin needs at least one low sample after the previous one (back-to-back high is one long pulse).
- Credit (when compiled in): on a coinValid edge credit += VALUE[i], saturating at 2^CREDIT_W−1. `creditClear` zeroes credit; simultaneous clear and valid coin → credit = VALUE[i] (clear then add).
- Width = number of consecutive rising edges sampling `coinSensor`=1.

## Timing
- All outputs registered. Reset values: coinValid=0, coinDetected=0, coinIndex=0, coinReject=0, jam=0, credit=0.
- Classification latency: coinValid/coinReject high in the cycle immediately after the edge that first samples `coinSensor`=0; exactly one cycle wide.
- credit reflects the new coin in the same cycle coinValid is high.
- jam rises the cycle after the JAM_LIMIT-th high sample; falls the cycle after the first low sample.
- creditClear effective on the next edge; credit=0 the following cycle.
- Reset mid-MEASURE or mid-JAM: count dropped, no pulse issued, credit zeroed, state SETTLE.

## Configuration
- `COIN_CREDIT_EN` defined: credit accumulator and `creditClear` logic present as above.
- Not defined: no accumulator; `credit` tied to 0, `creditClear` ignored; classification unchanged.

## Test plan
- Reset, sensor low 3 cycles → all outputs 0, state IDLE, no pulses.
- Widths 2,4,6,8,10,12 (one low cycle between) → coinIndex 0,0,1,1,2,2 each with one-cycle coinValid; credit (macro on) = 10,20,25,30,55,80.
- Widths 1,5,9,13 → coinReject one cycle each, coinValid never high, credit unchanged.
- Sensor held high 255 cycles → jam high from cycle 256 until one cycle after release; no coinValid/coinReject.
- creditClear asserted on the edge classifying a width-10 coin with credit=40 → credit=25.
- Reset asserted at width 3 with sensor still high, released, sensor high 5 more cycles then low → no classification; next 3-cycle coin → coinIndex 0.
